bus_addr_demux: RTL

//  Parametrised successor to the fixed 2x8 address demux of the expansion CPLD.

---
 rtl/bus_addr_demux_pkg.sv | 22 ++
 rtl/bus_addr_demux_if.sv | 42 ++++
 rtl/bus_dir_turnaround.sv | 91 +++++++++
 rtl/bus_addr_demux.sv | 118 +++++++++++
 4 files changed

// File: rtl/bus_addr_demux_pkg.sv
// Shared types and constants for the expansion-bus address demux and its
// data-direction turnaround FSM.
package bus_addr_demux_pkg;

    // Data-direction FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        DirRd     = 2'b00,
        DirTurnWr = 2'b01,
        DirWr     = 2'b10,
        DirTurnRd = 2'b11
    } dir_state_e;

    // Turnaround counter width; covers 0..15 dead cycles.
    localparam int unsigned TurnCntW = 4;
    localparam int unsigned TurnMax  = 15;

    // Width of the slice index; at least one bit even for a single slice.
    function automatic int unsigned idx_width(int unsigned slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_demux_if.sv
// Bundle of the multiplexed address pins, core write strobe and the
// committed-address / data-enable outputs of the expansion demux.
interface bus_addr_demux_if #(
    parameter int unsigned SliceW = 8,
    parameter int unsigned Slices = 2
) ();

    logic                     mux_sync;
    logic [SliceW-1:0]        mux_d;
    logic                     cpu_wr_n;
    logic                     err_clr;
    logic [SliceW*Slices-1:0] a_out;
    logic                     a_valid;
    logic                     frame_err;
    logic                     d_to_bus_oe;
    logic                     d_to_core_oe;

    modport master (
        output mux_sync,
        output mux_d,
        output cpu_wr_n,
        output err_clr,
        input  a_out,
        input  a_valid,
        input  frame_err,
        input  d_to_bus_oe,
        input  d_to_core_oe
    );

    modport slave (
        input  mux_sync,
        input  mux_d,
        input  cpu_wr_n,
        input  err_clr,
        output a_out,
        output a_valid,
        output frame_err,
        output d_to_bus_oe,
        output d_to_core_oe
    );

endinterface

// File: rtl/bus_dir_turnaround.sv
// Data-direction FSM: switches between core->bus and bus->core driving with
// Turn dead cycles (both enables low) on every direction change.
module bus_dir_turnaround
    import bus_addr_demux_pkg::*;
#(
    parameter int unsigned Turn = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_wr_n_i,
    output logic d_to_bus_oe_o,
    output logic d_to_core_oe_o
);

    localparam logic [TurnCntW-1:0] TurnLast =
        (Turn == 0) ? '0 : TurnCntW'(Turn - 1);

    dir_state_e          state_q, state_d;
    logic [TurnCntW-1:0] cnt_q, cnt_d;
    logic                bus_oe_q, bus_oe_d;
    logic                core_oe_q, core_oe_d;
    logic                turn_done;

    assign turn_done = (Turn == 0) || (cnt_q == TurnLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DirRd: begin
                if (!cpu_wr_n_i) begin
                    state_d = (Turn == 0) ? DirWr : DirTurnWr;
                    cnt_d   = '0;
                end
            end
            DirWr: begin
                if (cpu_wr_n_i) begin
                    state_d = (Turn == 0) ? DirRd : DirTurnRd;
                    cnt_d   = '0;
                end
            end
            DirTurnWr: begin
                // Strobe reversal mid-turnaround restarts the dead time the other way.
                if (cpu_wr_n_i) begin
                    state_d = (Turn == 0) ? DirRd : DirTurnRd;
                    cnt_d   = '0;
                end else if (turn_done) begin
                    state_d = DirWr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DirTurnRd: begin
                if (!cpu_wr_n_i) begin
                    state_d = (Turn == 0) ? DirWr : DirTurnWr;
                    cnt_d   = '0;
                end else if (turn_done) begin
                    state_d = DirRd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DirTurnRd;
                cnt_d   = '0;
            end
        endcase

        // Enables decode from the next state so they are registered yet exclusive.
        bus_oe_d  = (state_d == DirWr);
        core_oe_d = (state_d == DirRd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DirTurnRd;
            cnt_q     <= '0;
            bus_oe_q  <= 1'b0;
            core_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_oe_q  <= bus_oe_d;
            core_oe_q <= core_oe_d;
        end
    end

    assign d_to_bus_oe_o  = bus_oe_q;
    assign d_to_core_oe_o = core_oe_q;

endmodule

// File: rtl/bus_addr_demux.sv
// Rebuilds a wide expansion-bus address from time-multiplexed slices, commits
// it atomically with a valid pulse, and drives the data-direction enables.
module bus_addr_demux
    import bus_addr_demux_pkg::*;
#(
    parameter int unsigned SliceW   = 8,
    parameter int unsigned Slices   = 2,
    parameter bit          RepeatLs = 1'b1,
    parameter int unsigned Turn     = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    bus_addr_demux_if.slave bus
);

    localparam int unsigned    AddrW   = SliceW * Slices;
    localparam int unsigned    IdxW    = idx_width(Slices);
    localparam int unsigned    ShadowN = (Slices > 1) ? Slices - 1 : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Slices - 1);

    logic [IdxW-1:0]                idx_q, idx_d;
    logic [ShadowN-1:0][SliceW-1:0] shadow_q, shadow_d;
    logic [AddrW-1:0]               a_out_q, a_out_d;
    logic [AddrW-1:0]               assembled;
    logic                           a_valid_q, a_valid_d;
    logic                           frame_err_q, frame_err_d;
    logic                           err_set;
    logic                           bus_oe, core_oe;

    // Full address as it would look if the current slice were the last one.
    always_comb begin
        assembled              = '0;
        assembled[SliceW-1:0]  = bus.mux_d;
        for (int i = 0; i < int'(Slices) - 1; i++) begin
            assembled[(int'(Slices) - 1 - i) * int'(SliceW) +: SliceW] = shadow_q[i];
        end
    end

    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        a_out_d   = a_out_q;
        a_valid_d = 1'b0;
        err_set   = 1'b0;

        if (bus.mux_sync) begin
            // A sync while mid-frame means the previous frame was cut short.
            err_set = (idx_q != '0);
            if (Slices == 1) begin
                a_out_d   = assembled;
                a_valid_d = 1'b1;
                idx_d     = '0;
            end else begin
                shadow_d[0] = bus.mux_d;
                idx_d       = IdxW'(1);
            end
        end else if (idx_q == '0) begin
            if (RepeatLs) begin
                a_out_d[SliceW-1:0] = bus.mux_d;
                a_valid_d           = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end else if (idx_q == LastIdx) begin
            a_out_d   = assembled;
            a_valid_d = 1'b1;
            idx_d     = '0;
        end else begin
            for (int i = 0; i < int'(ShadowN); i++) begin
                if (idx_q == IdxW'(i)) begin
                    shadow_d[i] = bus.mux_d;
                end
            end
            idx_d = idx_q + 1'b1;
        end

        if (err_set) begin
            frame_err_d = 1'b1;
        end else if (bus.err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            a_out_q     <= '0;
            a_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            a_out_q     <= a_out_d;
            a_valid_q   <= a_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    bus_dir_turnaround #(
        .Turn (Turn)
    ) u_dir (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_wr_n_i     (bus.cpu_wr_n),
        .d_to_bus_oe_o  (bus_oe),
        .d_to_core_oe_o (core_oe)
    );

    assign bus.a_out        = a_out_q;
    assign bus.a_valid      = a_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.d_to_bus_oe  = bus_oe;
    assign bus.d_to_core_oe = core_oe;

endmodule
